// File: rtl/usb3300_ulpi_tx.sv
`default_nettype none
// ==========================================================================
// usb3300_ulpi_tx : link-side ULPI transmit engine (TXCMD, data, STP, retry)
// Optional USB CRC16 append on DATA PIDs: define ULPI_TX_CRC16_EN.  Rev 1.0
// ==========================================================================
module usb3300_ulpi_tx #(
  parameter int RETRY_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       ulpi_stp,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_turn   = 3'd1;
  localparam logic [2:0] c_cmd    = 3'd2;
  localparam logic [2:0] c_data   = 3'd3;
  localparam logic [2:0] c_crc_lo = 3'd4;
  localparam logic [2:0] c_crc_hi = 3'd5;
  localparam logic [2:0] c_stop   = 3'd6;
  localparam logic [2:0] c_drain  = 3'd7;
  localparam logic [7:0] c_retry_max = 8'(RETRY_MAX);

  logic [2:0]  state, state_n;
  logic [3:0]  pid, pid_n;
  logic        pid_last, pid_last_n;
  logic        last_seen, last_seen_n;
  logic        busy_n;
  logic [7:0]  retry_cnt, retry_n;
  logic [7:0]  hold_data, hold_data_n;
  logic        hold_valid, hold_valid_n;
  logic        hold_last, hold_last_n;
  logic [7:0]  data_n;
  logic        oe_n, stp_n, done_n, err_n;
  logic        accept, consume, load_hold, crc_apply;
  logic        to_stop, to_abort, to_underrun;
  logic [15:0] crc, crc_upd;

  assign consume   = (state == c_data) && ulpi_nxt && !ulpi_dir;
  assign accept    = tx_valid && tx_ready;
  assign load_hold = accept && ((state == c_turn) || (state == c_cmd) || (state == c_data));

  // Once tx_last is in, nothing more is taken so the next PID cannot slip into the payload.
  always_comb begin
    case (state)
      c_idle:                 tx_ready = !ulpi_dir;
      c_turn, c_cmd, c_data:  tx_ready = !ulpi_dir && !last_seen && (!hold_valid || consume);
      c_drain:                tx_ready = !last_seen;
      default:                tx_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_n      = state;
    pid_n        = pid;
    pid_last_n   = pid_last;
    last_seen_n  = last_seen;
    busy_n       = tx_busy;
    retry_n      = retry_cnt;
    hold_data_n  = hold_data;
    hold_valid_n = hold_valid && !consume;
    hold_last_n  = hold_last;
    data_n       = ulpi_data_out;
    oe_n         = ulpi_data_oe;
    stp_n        = 1'b0;
    done_n       = 1'b0;
    err_n        = 1'b0;
    to_stop      = 1'b0;
    to_abort     = 1'b0;
    to_underrun  = 1'b0;

    if (load_hold) begin
      hold_data_n  = tx_data;
      hold_valid_n = 1'b1;
      hold_last_n  = tx_last;
    end
    if (accept && tx_last) last_seen_n = 1'b1;

    case (state)
      c_idle: begin
        retry_n      = 8'd0;
        oe_n         = 1'b0;
        data_n       = 8'h00;
        hold_valid_n = 1'b0;
        last_seen_n  = 1'b0;
        if (accept) begin
          pid_n       = tx_data[3:0];
          pid_last_n  = tx_last;
          last_seen_n = tx_last;
          busy_n      = 1'b1;
          state_n     = c_turn;
        end
      end
      c_turn: begin
        oe_n   = 1'b0;
        data_n = 8'h00;
        if (!ulpi_dir) begin
          state_n = c_cmd;
          oe_n    = 1'b1;
          data_n  = {4'b0100, pid};
        end
      end
      c_cmd: begin
        if (ulpi_dir) begin
          oe_n   = 1'b0;
          data_n = 8'h00;
          if (retry_cnt == c_retry_max) begin
            err_n   = 1'b1;
            state_n = c_drain;
          end else begin
            retry_n = retry_cnt + 8'd1;
            state_n = c_turn;
          end
        end else if (ulpi_nxt) begin
          if (pid_last) begin
            if (crc_apply) begin
              state_n = c_crc_lo;
              data_n  = ~crc[7:0];
            end else begin
              to_stop = 1'b1;
            end
          end else if (hold_valid_n) begin
            state_n = c_data;
            data_n  = hold_data_n;
          end else begin
            to_underrun = 1'b1;
          end
        end
      end
      c_data: begin
        if (ulpi_dir) begin
          to_abort = 1'b1;
        end else if (ulpi_nxt) begin
          if (hold_last) begin
            if (crc_apply) begin
              state_n = c_crc_lo;
              data_n  = ~crc_upd[7:0];
            end else begin
              to_stop = 1'b1;
            end
          end else if (hold_valid_n) begin
            data_n = hold_data_n;
          end else begin
            to_underrun = 1'b1;
          end
        end
      end
      c_crc_lo: begin
        if (ulpi_dir) begin
          to_abort = 1'b1;
        end else if (ulpi_nxt) begin
          state_n = c_crc_hi;
          data_n  = ~crc[15:8];
        end
      end
      c_crc_hi: begin
        if (ulpi_dir) to_abort = 1'b1;
        else if (ulpi_nxt) to_stop = 1'b1;
      end
      c_stop: begin
        state_n = c_idle;
        oe_n    = 1'b0;
        data_n  = 8'h00;
        busy_n  = 1'b0;
      end
      c_drain: begin
        oe_n         = 1'b0;
        data_n       = 8'h00;
        hold_valid_n = 1'b0;
        if (last_seen || (accept && tx_last)) begin
          state_n = c_idle;
          busy_n  = 1'b0;
        end
      end
      default: state_n = c_idle;
    endcase

    if (to_stop) begin
      state_n = c_stop;
      data_n  = 8'h00;
      stp_n   = 1'b1;
      done_n  = 1'b1;
    end
    if (to_abort) begin
      state_n = c_drain;
      oe_n    = 1'b0;
      data_n  = 8'h00;
      err_n   = 1'b1;
    end
    // Underrun: 0xFF with STP tells the PHY to corrupt the packet on the wire.
    if (to_underrun) begin
      state_n = c_drain;
      oe_n    = 1'b1;
      data_n  = 8'hFF;
      stp_n   = 1'b1;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= c_idle;
      pid           <= 4'h0;
      pid_last      <= 1'b0;
      last_seen     <= 1'b0;
      tx_busy       <= 1'b0;
      retry_cnt     <= 8'd0;
      hold_data     <= 8'h00;
      hold_valid    <= 1'b0;
      hold_last     <= 1'b0;
      ulpi_data_out <= 8'h00;
      ulpi_data_oe  <= 1'b0;
      ulpi_stp      <= 1'b0;
      tx_done       <= 1'b0;
      tx_err        <= 1'b0;
    end else begin
      state         <= state_n;
      pid           <= pid_n;
      pid_last      <= pid_last_n;
      last_seen     <= last_seen_n;
      tx_busy       <= busy_n;
      retry_cnt     <= retry_n;
      hold_data     <= hold_data_n;
      hold_valid    <= hold_valid_n;
      hold_last     <= hold_last_n;
      ulpi_data_out <= data_n;
      ulpi_data_oe  <= oe_n;
      ulpi_stp      <= stp_n;
      tx_done       <= done_n;
      tx_err        <= err_n;
    end
  end

`ifdef ULPI_TX_CRC16_EN
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign crc_apply = (pid[1:0] == 2'b11);
  assign crc_upd   = crc16_byte(crc, hold_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           crc <= 16'hFFFF;
    else if (state == c_idle && accept) crc <= 16'hFFFF;
    else if (consume)                  crc <= crc_upd;
  end
`else
  assign crc_apply = 1'b0;
  assign crc       = 16'hFFFF;
  assign crc_upd   = 16'hFFFF;
`endif

endmodule
`default_nettype wire
